// File: rtl/osd_overlay.sv
// osd_overlay: tracks pixel position from video timing, reads a 1-bpp bitmap
// from osd_ram and paints foreground-coloured pixels inside a fixed window.
// All video outputs are delayed by exactly three pixel clocks.
module osd_overlay #(
  parameter int ADDR_WIDTH = 11,
  parameter int OSD_W      = 256,
  parameter int OSD_X      = 100,
  parameter int OSD_Y      = 50,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vs_in,
  input  logic                  hs_in,
  input  logic                  de_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  osd_en,
  input  logic [DATA_WIDTH-1:0] osd_color,
  output logic [ADDR_WIDTH-1:0] osd_rd_addr,
  input  logic [7:0]            osd_rd_data,
  output logic                  vs_out,
  output logic                  hs_out,
  output logic                  de_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int OSD_H = (2**ADDR_WIDTH) * 8 / OSD_W;
  localparam int XB    = $clog2(OSD_W);
  localparam int YB    = $clog2(OSD_H);

  // Window bounds held one bit wider so OSD_X+OSD_W cannot wrap.
  localparam logic [12:0] X_LO = 13'(OSD_X);
  localparam logic [12:0] X_HI = 13'(OSD_X + OSD_W);
  localparam logic [12:0] Y_LO = 13'(OSD_Y);
  localparam logic [12:0] Y_HI = 13'(OSD_Y + OSD_H);

  // Only the low bits of the window-relative position are ever used, and
  // modular subtraction on those bits gives the same result.
  localparam logic [XB-1:0] X_OFF = XB'(OSD_X);
  localparam logic [YB-1:0] Y_OFF = YB'(OSD_Y);

  localparam logic [11:0] CNT_MAX = 12'hFFF;

  // Position counters
  logic [11:0]           x_cnt_q, x_cnt_d;
  logic [11:0]           y_cnt_q, y_cnt_d;

  // Stage 1
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  hit1_q, hit1_d;
  logic [2:0]            bitsel1_q, bitsel1_d;
  logic                  vs1_q, vs1_d;
  logic                  hs1_q, hs1_d;
  logic                  de1_q, de1_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;

  // Stage 2
  logic                  hit2_q, hit2_d;
  logic [2:0]            bitsel2_q, bitsel2_d;
  logic                  vs2_q, vs2_d;
  logic                  hs2_q, hs2_d;
  logic                  de2_q, de2_d;
  logic [DATA_WIDTH-1:0] data2_q, data2_d;

  // Output stage
  logic                  vs_out_q, vs_out_d;
  logic                  hs_out_q, hs_out_d;
  logic                  de_out_q, de_out_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  // Stage-0 combinational helpers
  logic [XB-1:0]         x_rel_s;
  logic [YB-1:0]         y_rel_s;
  logic                  in_x_s;
  logic                  in_y_s;
  logic                  hit_s;
  logic                  de_fall_s;
  logic                  vs_rise_s;
  logic [ADDR_WIDTH-1:0] addr_s;

  // Next-state logic: counters, window hit/address, and the pixel pipeline.
  always_comb begin
    // de1_q / vs1_q are exactly the previous-cycle de_in / vs_in.
    de_fall_s = de1_q & ~de_in;
    vs_rise_s = ~vs1_q & vs_in;

    x_rel_s = x_cnt_q[XB-1:0] - X_OFF;
    y_rel_s = y_cnt_q[YB-1:0] - Y_OFF;
    in_x_s  = ({1'b0, x_cnt_q} >= X_LO) && ({1'b0, x_cnt_q} < X_HI);
    in_y_s  = ({1'b0, y_cnt_q} >= Y_LO) && ({1'b0, y_cnt_q} < Y_HI);
    hit_s   = de_in & osd_en & in_x_s & in_y_s;
    addr_s  = ADDR_WIDTH'({y_rel_s, x_rel_s[XB-1:3]});

    // Column counter: index of the current pixel while de_in is high.
    if (de_in) begin
      if (x_cnt_q == CNT_MAX) begin
        x_cnt_d = x_cnt_q;
      end else begin
        x_cnt_d = x_cnt_q + 12'd1;
      end
    end else begin
      x_cnt_d = 12'd0;
    end

    // Line counter: frame start clear takes priority over end-of-line step.
    if (vs_rise_s) begin
      y_cnt_d = 12'd0;
    end else if (de_fall_s && (y_cnt_q != CNT_MAX)) begin
      y_cnt_d = y_cnt_q + 12'd1;
    end else begin
      y_cnt_d = y_cnt_q;
    end

    // RAM address only moves on a window hit so the last fetch is held.
    if (hit_s) begin
      rd_addr_d = addr_s;
    end else begin
      rd_addr_d = rd_addr_q;
    end

    hit1_d    = hit_s;
    bitsel1_d = 3'd7 - x_rel_s[2:0];
    vs1_d     = vs_in;
    hs1_d     = hs_in;
    de1_d     = de_in;
    data1_d   = data_in;

    hit2_d    = hit1_q;
    bitsel2_d = bitsel1_q;
    vs2_d     = vs1_q;
    hs2_d     = hs1_q;
    de2_d     = de1_q;
    data2_d   = data1_q;

    // osd_rd_data now holds the byte for the pixel sitting in stage 2.
    if (hit2_q && osd_rd_data[bitsel2_q]) begin
      data_out_d = osd_color;
    end else begin
      data_out_d = data2_q;
    end
    vs_out_d = vs2_q;
    hs_out_d = hs2_q;
    de_out_d = de2_q;
  end

  // State and pipeline registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt_q    <= 12'd0;
      y_cnt_q    <= 12'd0;
      rd_addr_q  <= '0;
      hit1_q     <= 1'b0;
      bitsel1_q  <= 3'd0;
      vs1_q      <= 1'b0;
      hs1_q      <= 1'b0;
      de1_q      <= 1'b0;
      data1_q    <= '0;
      hit2_q     <= 1'b0;
      bitsel2_q  <= 3'd0;
      vs2_q      <= 1'b0;
      hs2_q      <= 1'b0;
      de2_q      <= 1'b0;
      data2_q    <= '0;
      vs_out_q   <= 1'b0;
      hs_out_q   <= 1'b0;
      de_out_q   <= 1'b0;
      data_out_q <= '0;
    end else begin
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      rd_addr_q  <= rd_addr_d;
      hit1_q     <= hit1_d;
      bitsel1_q  <= bitsel1_d;
      vs1_q      <= vs1_d;
      hs1_q      <= hs1_d;
      de1_q      <= de1_d;
      data1_q    <= data1_d;
      hit2_q     <= hit2_d;
      bitsel2_q  <= bitsel2_d;
      vs2_q      <= vs2_d;
      hs2_q      <= hs2_d;
      de2_q      <= de2_d;
      data2_q    <= data2_d;
      vs_out_q   <= vs_out_d;
      hs_out_q   <= hs_out_d;
      de_out_q   <= de_out_d;
      data_out_q <= data_out_d;
    end
  end

  assign osd_rd_addr = rd_addr_q;
  assign vs_out      = vs_out_q;
  assign hs_out      = hs_out_q;
  assign de_out      = de_out_q;
  assign data_out    = data_out_q;

endmodule

// File: tb/tb_osd_overlay.sv
// Testbench for osd_overlay: probe table of hand-computed pixel results plus
// a cycle-by-cycle reference model of the 3-clock pipeline and RAM address.
module tb_osd_overlay;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs_in, hs_in, de_in, osd_en;
  logic [23:0] data_in, osd_color;
  logic [10:0] osd_rd_addr;
  logic [7:0]  osd_rd_data;
  logic        vs_out, hs_out, de_out;
  logic [23:0] data_out;

  osd_overlay dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .data_in(data_in), .osd_en(osd_en), .osd_color(osd_color),
    .osd_rd_addr(osd_rd_addr), .osd_rd_data(osd_rd_data),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // osd_ram model, OUTPUT_REG=0: data follows the address latched at the edge.
  logic [7:0] mem [0:2047];
  always @(posedge clk) osd_rd_data <= mem[osd_rd_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-capture-edge record of what went in and what must come out.
  typedef struct {
    logic        vs, hs, de;
    logic [23:0] din;
    logic [23:0] exp_data;
    logic [10:0] exp_addr;
    int          x, y, frm;
  } hrec_t;

  hrec_t       hist [8];
  int          ecount = 0;
  int          cur_x = 0, cur_y = 0, cur_frm = 0;
  logic [10:0] model_addr = 11'd0;

  typedef struct {
    int          frm, x, y;
    logic [10:0] addr;
    logic        over;
  } probe_t;

  localparam int NP = 16;
  probe_t probes [NP];

  // Reference model: evaluated at every capture edge from the generator's own x/y.
  initial forever begin
    hrec_t r;
    int xr, yr, a;
    logic ov;
    @(posedge clk);
    ecount++;
    ov = 1'b0;
    if (rst) begin
      model_addr = 11'd0;
      r.vs = 1'b0; r.hs = 1'b0; r.de = 1'b0;
      r.din = 24'd0; r.exp_data = 24'd0;
    end else begin
      if (de_in && osd_en && cur_x >= 100 && cur_x < 356 && cur_y >= 50 && cur_y < 114) begin
        xr = cur_x - 100;
        yr = cur_y - 50;
        a  = yr * 32 + xr / 8;
        model_addr = 11'(a);
        ov = mem[a][7 - (xr % 8)];
      end
      r.vs = vs_in; r.hs = hs_in; r.de = de_in;
      r.din = data_in;
      r.exp_data = ov ? osd_color : data_in;
    end
    r.exp_addr = model_addr;
    r.x = cur_x; r.y = cur_y; r.frm = cur_frm;
    hist[ecount & 7] = r;
  end

  // Checker: outputs against the record from 2 edges earlier, address against now.
  initial forever begin
    hrec_t o, c;
    int n;
    @(negedge clk);
    if (!rst && ecount >= 3) begin
      n = ecount;
      o = hist[(n - 2) & 7];
      c = hist[n & 7];
      chk("pipe", 64'({vs_out, hs_out, de_out, data_out}), 64'({o.vs, o.hs, o.de, o.exp_data}));
      chk("addr", 64'(osd_rd_addr), 64'(c.exp_addr));
      for (int i = 0; i < NP; i++) begin
        if (c.de && c.frm == probes[i].frm && c.x == probes[i].x && c.y == probes[i].y)
          chk($sformatf("probe%0d_addr", i), 64'(osd_rd_addr), 64'(probes[i].addr));
        if (o.de && o.frm == probes[i].frm && o.x == probes[i].x && o.y == probes[i].y)
          chk($sformatf("probe%0d_data", i), 64'(data_out),
              64'(probes[i].over ? osd_color : o.din));
      end
    end
  end

  task automatic drive(input logic v, input logic h, input logic d, input logic [23:0] pix,
                       input int x, input int y);
    @(posedge clk);
    #1;
    vs_in = v; hs_in = h; de_in = d; data_in = pix;
    cur_x = x; cur_y = y;
  endtask

  task automatic line(input int y, input int w, input int blank);
    for (int x = 0; x < w; x++) drive(1'b0, 1'b0, 1'b1, 24'h00FF00, x, y);
    for (int b = 0; b < blank; b++) drive(1'b0, (b == 1), 1'b0, 24'h000000, 0, y);
  endtask

  task automatic vsync();
    drive(1'b1, 1'b0, 1'b0, 24'h000000, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 24'h000000, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 24'h000000, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 24'h000000, 0, 0);
  endtask

  initial begin
    vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0; data_in = 24'd0;
    osd_en = 1'b1; osd_color = 24'hFF0000;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[0] = 8'h80; mem[32] = 8'h40; mem[640] = 8'h08; mem[2047] = 8'h01;

    //           frm  x    y    addr      over
    probes[0]  = '{1, 100,  49, 11'd0,    1'b0};
    probes[1]  = '{1,  99,  50, 11'd0,    1'b0};
    probes[2]  = '{1, 100,  50, 11'd0,    1'b1};
    probes[3]  = '{1, 101,  50, 11'd0,    1'b0};
    probes[4]  = '{1, 108,  50, 11'd1,    1'b0};
    probes[5]  = '{1, 355,  50, 11'd31,   1'b0};
    probes[6]  = '{1, 356,  50, 11'd31,   1'b0};
    probes[7]  = '{1, 100,  51, 11'd32,   1'b0};
    probes[8]  = '{1, 101,  51, 11'd32,   1'b1};
    probes[9]  = '{1, 355, 113, 11'd2047, 1'b1};
    probes[10] = '{1, 356, 113, 11'd2047, 1'b0};
    probes[11] = '{1, 100, 114, 11'd2047, 1'b0};
    probes[12] = '{2, 104,  70, 11'd640,  1'b1};
    probes[13] = '{3, 100,  49, 11'd641,  1'b0};
    probes[14] = '{3, 100,  50, 11'd0,    1'b1};
    probes[15] = '{5, 100,  50, 11'd0,    1'b1};

    // Power-on reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vs", 64'(vs_out), 64'd0);
    chk("rst_hs", 64'(hs_out), 64'd0);
    chk("rst_de", 64'(de_out), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_addr", 64'(osd_rd_addr), 64'd0);
    #2 rst = 1'b0;

    // Frame 1: full-size lines, whole window and its edges.
    cur_frm = 1;
    vsync();
    for (int y = 0; y < 116; y++) line(y, 360, 4);

    // Frame 2: vs rises on the same edge as the de fall ending line 70.
    cur_frm = 2;
    vsync();
    for (int y = 0; y < 70; y++) line(y, 110, 4);
    line(70, 110, 0);
    vsync();

    // Frame 3: the line after that vs must be line 0.
    cur_frm = 3;
    for (int y = 0; y < 53; y++) line(y, 110, 4);
    for (int x = 0; x < 30; x++) drive(1'b0, 1'b0, 1'b1, 24'h00FF00, x, 53);

    // Asynchronous reset in the middle of an active line.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_vs", 64'(vs_out), 64'd0);
    chk("mid_rst_hs", 64'(hs_out), 64'd0);
    chk("mid_rst_de", 64'(de_out), 64'd0);
    chk("mid_rst_data", 64'(data_out), 64'd0);
    chk("mid_rst_addr", 64'(osd_rd_addr), 64'd0);
    vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0; data_in = 24'd0;
    cur_x = 0; cur_y = 0; cur_frm = 5;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // After reset the counters restart at 0 without any vs.
    for (int b = 0; b < 4; b++) drive(1'b0, 1'b0, 1'b0, 24'h000000, 0, 0);
    for (int y = 0; y < 51; y++) line(y, 110, 4);

    // Overlay off with an all-0xFF bitmap: pure delayed pass-through.
    cur_frm = 6;
    osd_en = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'hFF;
    for (int k = 0; k < 600; k++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            24'($urandom), 0, 0);
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'b0, 24'h000000, 0, 0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
